treasure_detect_scheduler: RTL
==============================

Name: treasure_detect_scheduler

Overview:
- Sequences the image processor for a single treasure-detection request from the Arduino.
- Arms the processor on a clean frame boundary and clears its per-frame state at each frame start.
- Collects one shape/colour vote per frame over a fixed number of frames, takes a majority decision, and returns it over a four-phase REQ/ACK handshake.
- Sits between the image processor and the Arduino GPIO interface.

Parameters:
- N_FRAMES, 16: number of valid frame votes collected before a decision.
- MIN_VOTES, 9: minimum votes the winning shape needs, otherwise the result is "none".
- TIMEOUT_FRAMES, 64: maximum frame starts spent in COLLECT before a forced decision.
- SCREEN_HEIGHT, 144: last active line; lines above it are blanking.

Ports:
- CLK  in  1  pixel-domain clock, the same clock as the image processor.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  level from the Arduino; a rising edge requests a detection.
- VGA_PIXEL_Y  in  10  current line from the VGA/camera address generator.
- FRAME_VALID  in  1  one-cycle pulse from the processor when a frame classification is ready.
- FRAME_SHAPE  in  2  per-frame shape: 0 none, 1 triangle, 2 square, 3 diamond. Sampled on FRAME_VALID.
- FRAME_COLOR  in  1  per-frame colour: 0 red, 1 blue. Sampled on FRAME_VALID.
- PROC_ENABLE  out  1  processor may count pixels; high only in COLLECT.
- PROC_CLEAR  out  1  one-cycle pulse on each frame start in SYNC or COLLECT.
- RESULT  out  4  [3] colour (1 = blue), [2] triangle, [1] square, [0] diamond; one-hot or all zero.
- RESULT_VALID  out  1  REQ to the Arduino.
- RESULT_ACK  in  1  ACK from the Arduino.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset: one clock and reset as already decided; RESET is synchronous and active-high. When RESET is high at a CLK edge:
  - state goes to IDLE;
  - all counters and the START/Y history registers clear;
  - RESULT=0, RESULT_VALID=0, PROC_ENABLE=0, PROC_CLEAR=0, BUSY=0.
  - This applies from any state, including mid-handshake.
- Frame start: registered prev_y != 0 and VGA_PIXEL_Y == 0. It is detected combinationally; PROC_CLEAR is registered, so it appears one cycle later.
- States: IDLE, SYNC, COLLECT, DECIDE, PRESENT, RELEASE.
  - IDLE: on a START rising edge (registered history), clear vote and frame counters -> SYNC.
  - SYNC: on frame start, pulse PROC_CLEAR -> COLLECT. This guarantees the first collected frame is complete.
  - COLLECT:
    - PROC_ENABLE=1.
    - Each frame start increments frame_cnt and pulses PROC_CLEAR.
    - Each FRAME_VALID increments valid_cnt, the matching shape counter if FRAME_SHAPE != 0, and blue_cnt or red_cnt if FRAME_SHAPE != 0.
    - Exit to DECIDE when valid_cnt reaches N_FRAMES, or frame_cnt reaches TIMEOUT_FRAMES.
    - If both exit conditions occur in the same cycle, that FRAME_VALID is still counted.
  - DECIDE (one cycle):
    - Winner is the shape with the strictly greatest count, provided that count >= MIN_VOTES.
    - Any tie for the maximum, or a maximum below MIN_VOTES, gives RESULT=0.
    - Colour bit = 1 iff blue_cnt > red_cnt (a tie gives red). The colour bit is forced to 0 when there is no shape.
    - Register RESULT and set RESULT_VALID=1 -> PRESENT.
  - PRESENT: hold RESULT and RESULT_VALID until RESULT_ACK=1, then drop RESULT_VALID -> RELEASE.
  - RELEASE: wait for RESULT_ACK=0 -> IDLE. RESULT holds its value until the next DECIDE.
- Latency: Nth FRAME_VALID at cycle t -> DECIDE at t+1 -> RESULT/RESULT_VALID visible at t+2.
- Ignored inputs and edge cases:
  - START edges outside IDLE are ignored, with no queuing.
  - FRAME_VALID outside COLLECT is ignored.
  - A frame start and FRAME_VALID in the same cycle are both applied.
  - RESULT_ACK already high on entry to PRESENT: RESULT_VALID is still asserted for at least one cycle, then the FSM proceeds.
- Widths and counter rules:
  - Vote counters are $clog2(N_FRAMES+1) bits.
  - frame_cnt is $clog2(TIMEOUT_FRAMES+1) bits.
  - Counters saturate and never wrap.
- PROC_CLEAR never coincides with reset; it is 0 in IDLE, DECIDE, PRESENT and RELEASE.

Decomposition:
- Shared package treasure_pkg holds:
  - state enum;
  - shape codes (SHAPE_NONE/TRI/SQR/DIAM);
  - RESULT bit indices;
  - SCREEN_HEIGHT constant shared with the image processor.
- One sub-module, shape_vote_tally: shape/colour counters, saturation and the DECIDE comparison logic. It has a combinational winner output, registered by the scheduler FSM.

Test Plan:
- Reset mid-PRESENT with RESULT=4'b1010 -> next edge RESULT=0, RESULT_VALID=0, BUSY=0, state IDLE.
- START rise mid-frame (Y=70) -> no PROC_CLEAR until Y wraps 144->0; PROC_CLEAR 1 cycle later; PROC_ENABLE high from then.
- 16 FRAME_VALIDs, 12 square (10 blue) and 4 triangle -> RESULT=4'b1010, RESULT_VALID two cycles after the 16th pulse; holds until ACK; low the cycle after ACK; IDLE after ACK falls.
- 16 votes, 8 diamond / 8 triangle -> RESULT=4'b0000. Separately, 16 votes with 8 diamond and the rest none -> RESULT=0 (8 < MIN_VOTES).
- No FRAME_VALID for 64 frame starts -> DECIDE on the 64th, RESULT=0, RESULT_VALID=1.
- START toggled during COLLECT, and FRAME_VALID in IDLE -> no effect on counts or state. RESULT_ACK held high before PRESENT -> RESULT_VALID high for exactly 1 cycle.

Source files
------------

// File: rtl/treasure_detect_scheduler_pkg.sv
// Shared types and constants for the treasure detection scheduler and the
// image processor it sequences.
package treasure_pkg;

  // Last active VGA line; lines above it are vertical blanking.
  localparam int SCREEN_HEIGHT = 144;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_COLLECT,
    ST_DECIDE,
    ST_PRESENT,
    ST_RELEASE
  } sched_state_e;

  typedef enum logic [1:0] {
    SHAPE_NONE = 2'd0,
    SHAPE_TRI  = 2'd1,
    SHAPE_SQR  = 2'd2,
    SHAPE_DIAM = 2'd3
  } shape_e;

  // Bit positions inside RESULT.
  localparam int RES_DIAM = 0;
  localparam int RES_SQR  = 1;
  localparam int RES_TRI  = 2;
  localparam int RES_BLUE = 3;

endpackage

// File: rtl/treasure_detect_scheduler_if.sv
// Bundle of the processor-side and Arduino-side signals of the scheduler.
// master = scheduler side, slave = processor / Arduino / bench side.
interface treasure_detect_scheduler_if;
  logic       START;
  logic [9:0] VGA_PIXEL_Y;
  logic       FRAME_VALID;
  logic [1:0] FRAME_SHAPE;
  logic       FRAME_COLOR;
  logic       PROC_ENABLE;
  logic       PROC_CLEAR;
  logic [3:0] RESULT;
  logic       RESULT_VALID;
  logic       RESULT_ACK;
  logic       BUSY;

  modport master (
    input  START, VGA_PIXEL_Y, FRAME_VALID, FRAME_SHAPE, FRAME_COLOR, RESULT_ACK,
    output PROC_ENABLE, PROC_CLEAR, RESULT, RESULT_VALID, BUSY
  );

  modport slave (
    output START, VGA_PIXEL_Y, FRAME_VALID, FRAME_SHAPE, FRAME_COLOR, RESULT_ACK,
    input  PROC_ENABLE, PROC_CLEAR, RESULT, RESULT_VALID, BUSY
  );
endinterface

// File: rtl/treasure_detect_scheduler_tally.sv
// Per-request shape/colour vote counters with a combinational majority
// decision. The scheduler registers the winner while in DECIDE.
module shape_vote_tally
  import treasure_pkg::*;
#(
  parameter int N_FRAMES  = 16,
  parameter int MIN_VOTES = 9,
  localparam int CW = $clog2(N_FRAMES + 1)
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       clr,
  input  logic       vote,
  input  logic [1:0] shape,
  input  logic       color,
  output logic       done,
  output logic [3:0] winner
);

  logic [CW-1:0] valid_cnt, tri_cnt, sqr_cnt, diam_cnt, blue_cnt, red_cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The vote being counted this cycle can itself complete the set.
  assign done = (valid_cnt == CW'(N_FRAMES)) ||
                (vote && valid_cnt == CW'(N_FRAMES - 1));

  // Saturating vote counters; colour only counts when a shape was seen.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      valid_cnt <= '0;
      tri_cnt   <= '0;
      sqr_cnt   <= '0;
      diam_cnt  <= '0;
      blue_cnt  <= '0;
      red_cnt   <= '0;
    end else if (vote) begin
      valid_cnt <= sat_inc(valid_cnt);
      case (shape_e'(shape))
        SHAPE_TRI:  tri_cnt  <= sat_inc(tri_cnt);
        SHAPE_SQR:  sqr_cnt  <= sat_inc(sqr_cnt);
        SHAPE_DIAM: diam_cnt <= sat_inc(diam_cnt);
        default: ;
      endcase
      if (shape != SHAPE_NONE) begin
        if (color) blue_cnt <= sat_inc(blue_cnt);
        else       red_cnt  <= sat_inc(red_cnt);
      end
    end
  end

  // Strict maximum with a quorum; ties or a weak maximum give no shape.
  always_comb begin
    winner = '0;
    if (tri_cnt > sqr_cnt && tri_cnt > diam_cnt && tri_cnt >= CW'(MIN_VOTES))
      winner[RES_TRI] = 1'b1;
    else if (sqr_cnt > tri_cnt && sqr_cnt > diam_cnt && sqr_cnt >= CW'(MIN_VOTES))
      winner[RES_SQR] = 1'b1;
    else if (diam_cnt > tri_cnt && diam_cnt > sqr_cnt && diam_cnt >= CW'(MIN_VOTES))
      winner[RES_DIAM] = 1'b1;
    if (|winner[2:0])
      winner[RES_BLUE] = (blue_cnt > red_cnt);
  end

endmodule

// File: rtl/treasure_detect_scheduler.sv
// Sequences the image processor for one treasure-detection request:
// sync to a frame boundary, collect per-frame votes, decide by majority and
// return the result over a four-phase REQ/ACK handshake.
module treasure_detect_scheduler
  import treasure_pkg::*;
#(
  parameter int N_FRAMES       = 16,
  parameter int MIN_VOTES      = 9,
  parameter int TIMEOUT_FRAMES = 64
) (
  input logic                          CLK,
  input logic                          RESET,
  treasure_detect_scheduler_if.master  bus
);

  localparam int FW = $clog2(TIMEOUT_FRAMES + 1);

  sched_state_e  state, state_nxt;
  logic          start_q;
  logic [9:0]    y_q;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    result_q;
  logic          rv_q;
  logic          clr_q;

  logic          start_rise, frame_start, vote, tally_clr, vote_done, frame_done;
  logic [3:0]    winner;

  assign start_rise  = bus.START && !start_q;
  assign frame_start = (y_q != 10'd0) && (bus.VGA_PIXEL_Y == 10'd0);
  assign vote        = bus.FRAME_VALID && (state == ST_COLLECT);
  assign tally_clr   = (state == ST_IDLE) && start_rise;
  assign frame_done  = (frame_cnt == FW'(TIMEOUT_FRAMES)) ||
                       (frame_start && (state == ST_COLLECT) &&
                        frame_cnt == FW'(TIMEOUT_FRAMES - 1));

  shape_vote_tally #(
    .N_FRAMES  (N_FRAMES),
    .MIN_VOTES (MIN_VOTES)
  ) u_tally (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    (tally_clr),
    .vote   (vote),
    .shape  (bus.FRAME_SHAPE),
    .color  (bus.FRAME_COLOR),
    .done   (vote_done),
    .winner (winner)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_rise)              state_nxt = ST_SYNC;
      ST_SYNC:    if (frame_start)             state_nxt = ST_COLLECT;
      ST_COLLECT: if (vote_done || frame_done) state_nxt = ST_DECIDE;
      ST_DECIDE:                               state_nxt = ST_PRESENT;
      ST_PRESENT: if (bus.RESULT_ACK)          state_nxt = ST_RELEASE;
      ST_RELEASE: if (!bus.RESULT_ACK)         state_nxt = ST_IDLE;
      default:                                 state_nxt = ST_IDLE;
    endcase
  end

  // Edge history, frame counting, clear pulse and the result handshake.
  // A frame start that ends collection does not clear the processor, so
  // the clear pulse never lands in DECIDE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_q   <= 1'b0;
      y_q       <= '0;
      frame_cnt <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      start_q <= bus.START;
      y_q     <= bus.VGA_PIXEL_Y;
      clr_q   <= frame_start && (state_nxt == ST_COLLECT);
      if (tally_clr)
        frame_cnt <= '0;
      else if (state == ST_COLLECT && frame_start && !(&frame_cnt))
        frame_cnt <= frame_cnt + 1'b1;
      if (state == ST_DECIDE) begin
        result_q <= winner;
        rv_q     <= 1'b1;
      end else if (state == ST_PRESENT && bus.RESULT_ACK) begin
        rv_q     <= 1'b0;
      end
    end
  end

  assign bus.PROC_ENABLE  = (state == ST_COLLECT);
  assign bus.PROC_CLEAR   = clr_q;
  assign bus.RESULT       = result_q;
  assign bus.RESULT_VALID = rv_q;
  assign bus.BUSY         = (state != ST_IDLE);

endmodule
